// File: rtl/mod_rx_commut_sched.sv
// Round-robin scheduler sharing one narrow-to-wide receive commutator among N_REQ requesters.
// Streams the winner's beats, waits for the assembled word and returns it with the requester id.
module mod_rx_commut_sched #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*IN_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          beat_take,
  output logic                      commut_start,
  output logic [IN_WIDTH-1:0]       commut_in,
  input  logic                      commut_ready,
  input  logic [OUT_WIDTH-1:0]      commut_out,
  output logic                      out_valid,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      err
);

  localparam int BEATS = OUT_WIDTH / IN_WIDTH;
  localparam int BCW   = $clog2(BEATS + 1);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_OUT} state_t;

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_grant, r_last_grant, w_pick;
  logic                  w_found, w_gvalid;
  logic [IN_WIDTH-1:0]   w_beat;
  logic [BCW-1:0]        r_beat_cnt;
  logic [TW-1:0]         r_tmo_cnt;
  logic                  r_out_valid, r_err;
  logic [OUT_WIDTH-1:0]  r_out_data;
  logic [ID_W-1:0]       r_out_id;

  // Rotating priority: the requester at the smallest distance after last_grant wins.
  always_comb begin
    int w_dist;
    int w_best;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    w_dist  = 0;
    w_best  = N_REQ;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i - int'(r_last_grant) - 1 + 2 * N_REQ) % N_REQ;
      if (req_valid[i] && w_dist < w_best) begin
        w_best  = w_dist;
        w_pick  = ID_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    commut_start = 1'b0;
    commut_in    = '0;
    beat_take    = '0;
    w_beat       = '0;
    w_gvalid     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == ID_W'(i)) begin
        w_beat   = req_data[i*IN_WIDTH +: IN_WIDTH];
        w_gvalid = req_valid[i];
      end
    end
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_START;
      S_START: begin
        commut_start = 1'b1;
        w_state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        commut_in = w_beat;
        for (int i = 0; i < N_REQ; i++) beat_take[i] = (r_grant == ID_W'(i));
        if (r_beat_cnt == LAST_BEAT) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (commut_ready)                w_state_nxt = S_OUT;
        else if (r_tmo_cnt == TMO_LAST) w_state_nxt = S_IDLE;
      end
      S_OUT:    if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_LAST;
      r_beat_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE:  if (w_found) r_grant <= w_pick;
        S_START: r_beat_cnt <= '0;
        S_STREAM: begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          // A requester dropping valid mid-word is flagged but the word is still completed.
          if (!w_gvalid) r_err <= 1'b1;
          if (r_beat_cnt == LAST_BEAT) r_tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (commut_ready) begin
            r_out_valid <= 1'b1;
            r_out_data  <= commut_out;
            r_out_id    <= r_grant;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_err        <= 1'b1;
            r_last_grant <= r_grant;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_mod_rx_commut_sched.sv
// Self-checking bench: requester and commutator models, output scoreboard, vector table
// and hand-written sequences for backpressure, protocol drop, mid-stream reset and timeout.
module tb_mod_rx_commut_sched;

  localparam int IW = 8, OW = 32, NR = 4, IDW = 2, TMO = 64, BEATS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*IW-1:0] req_data;
  logic [NR-1:0]   beat_take;
  logic            commut_start;
  logic [IW-1:0]   commut_in;
  logic            commut_ready;
  logic [OW-1:0]   commut_out;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic [IDW-1:0]  out_id;
  logic            out_ready;
  logic            busy;
  logic            err;

  mod_rx_commut_sched #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .N_REQ(NR), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .beat_take(beat_take),
    .commut_start(commut_start), .commut_in(commut_in), .commut_ready(commut_ready),
    .commut_out(commut_out), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; logic [OW-1:0] data; } sb_t;
  typedef struct { int id; logic [31:0] word; int dly; logic [IDW-1:0] exp_id; logic [OW-1:0] exp_data; } vec_t;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;

  logic [31:0] rq_q [NR][$];
  int          bidx [NR];
  logic        drop [NR];
  sb_t         sb [$];

  logic [NR-1:0] take_s = '0;
  logic          cm_enable = 1'b1, cm_active = 1'b0;
  int            cm_delay = 1, cm_n = 0, ready_at = -1;
  logic [OW-1:0] cm_word = '0;

  int n_out = 0, n_takes = 0, arb_cyc = 0, start_cyc = 0, ov_cyc = 0, last_take_cyc = 0;
  int take_cycs [$];
  logic [IDW-1:0] got_ids [$];
  logic [IDW-1:0] last_id = '0;
  logic [OW-1:0]  last_data = '0;
  logic prev_ov = 1'b0, saw_out = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_outs(input int target, input int budget, input string name);
    int k = 0;
    while (n_out < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check(name, n_out, target);
  endtask

  // Requester and commutator drivers: update just after each rising edge.
  initial begin
    for (int i = 0; i < NR; i++) begin bidx[i] = 0; drop[i] = 1'b0; end
    req_valid = '0; req_data = '0; commut_ready = 1'b0; commut_out = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        for (int i = 0; i < NR; i++) bidx[i] = 0;
        cm_active = 1'b0; cm_n = 0; ready_at = -1;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (take_s[i] && rq_q[i].size() > 0) begin
            bidx[i]++;
            if (bidx[i] == BEATS) begin
              sb_t e;
              e.id = IDW'(i);
              e.data = rq_q[i][0];
              sb.push_back(e);
              void'(rq_q[i].pop_front());
              bidx[i] = 0;
              drop[i] = 1'b0;
            end
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        logic [31:0] w;
        w = (rq_q[i].size() > 0) ? rq_q[i][0] : 32'h0;
        req_valid[i] = (rq_q[i].size() > 0) && !(drop[i] && bidx[i] >= 1);
        req_data[i*IW +: IW] = w[bidx[i]*IW +: IW];
      end
      commut_ready = cm_enable && (cyc == ready_at);
      commut_out   = commut_ready ? cm_word : 32'hDEAD_BEEF;
    end
  end

  // Monitor and scoreboard: sample on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      take_s = beat_take;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (beat_take != '0) begin
          check("take_onehot", 64'($onehot(beat_take)), 64'd1);
          n_takes++;
          take_cycs.push_back(cyc);
          last_take_cyc = cyc;
        end
        if (commut_start) start_cyc = cyc;
        if (|req_valid && !busy) arb_cyc = cyc;
        if (out_valid && !prev_ov) ov_cyc = cyc;
        if (out_valid) saw_out = 1'b1;
        prev_ov = out_valid;
        if (cm_active && cm_n < BEATS) begin
          cm_word[cm_n*IW +: IW] = commut_in;
          cm_n++;
          if (cm_n == BEATS) ready_at = cyc + cm_delay;
        end
        if (commut_start) begin cm_active = 1'b1; cm_n = 0; cm_word = '0; end
        if (out_valid && out_ready) begin
          n_out++;
          got_ids.push_back(out_id);
          last_id = out_id;
          last_data = out_data;
          if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_unexpected: got id %0d data 0x%0h, none expected", out_id, out_data);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check("sb_id", out_id, e.id);
            check("sb_data", out_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  vec_t vecs [5];

  initial begin
    int base, bt, k, seen, e_cyc, t_first, t_last, gv;
    logic [OW-1:0]  cap_d;
    logic [IDW-1:0] cap_i;

    vecs[0] = '{0, 32'h0403_0201, 1,  2'd0, 32'h0403_0201};
    vecs[1] = '{3, 32'hFFEE_0080, 5,  2'd3, 32'hFFEE_0080};
    vecs[2] = '{1, 32'h1234_5678, 2,  2'd1, 32'h1234_5678};
    vecs[3] = '{2, 32'h0000_00FF, 10, 2'd2, 32'h0000_00FF};
    vecs[4] = '{3, 32'hA5A5_5A5A, 1,  2'd3, 32'hA5A5_5A5A};

    rst_n = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {beat_take, commut_start, commut_in, out_valid, out_data, out_id, busy, err}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy, out_valid, beat_take}, 64'd0);

    // Single requester 2, latency from arbitration.
    cm_delay = 3; take_cycs.delete(); base = n_out;
    @(posedge clk); #1 rq_q[2].push_back(32'hD4C3_B2A1);
    wait_outs(base + 1, 60, "t1_done");
    t_first = (take_cycs.size() > 0) ? take_cycs[0] : -100;
    t_last  = (take_cycs.size() > 0) ? take_cycs[take_cycs.size()-1] : -100;
    check("t1_start_lat", start_cyc - arb_cyc, 1);
    check("t1_ntake", take_cycs.size(), 4);
    check("t1_first_take", t_first - arb_cyc, 2);
    check("t1_last_take", t_last - arb_cyc, 5);
    check("t1_ov_lat", ov_cyc - arb_cyc, 9);
    check("t1_id", last_id, 2);
    check("t1_data", last_data, 32'hD4C3_B2A1);
    check("t1_err", err, 0);

    for (int v = 0; v < 5; v++) begin
      cm_delay = vecs[v].dly; base = n_out;
      @(posedge clk); #1 rq_q[vecs[v].id].push_back(vecs[v].word);
      wait_outs(base + 1, 100, $sformatf("vec%0d_done", v));
      check($sformatf("vec%0d_id", v), last_id, vecs[v].exp_id);
      check($sformatf("vec%0d_data", v), last_data, vecs[v].exp_data);
    end

    // All requesters busy for two words each: rotation 0,1,2,3,0,1,2,3.
    got_ids.delete(); base = n_out; cm_delay = 2;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++)
      for (int w = 0; w < 2; w++) rq_q[i].push_back(32'(32'hC0DE_0000 + i * 256 + w));
    wait_outs(base + 8, 600, "rr_done");
    for (int j = 0; j < 8; j++) begin
      gv = (got_ids.size() > j) ? int'(got_ids[j]) : 99;
      check($sformatf("rr_id%0d", j), gv, j % 4);
    end

    // Backpressure: output held 10 cycles, no new grant while req 2 waits.
    cm_delay = 1; base = n_out;
    @(posedge clk); #1 out_ready = 1'b0;
    rq_q[1].push_back(32'h0BAD_F00D); rq_q[2].push_back(32'h600D_CAFE);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 100);
    check("bp_valid", out_valid, 1);
    cap_d = out_data; cap_i = out_id;
    check("bp_id", cap_i, 1);
    check("bp_data", cap_d, 32'h0BAD_F00D);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 10) out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {out_valid, out_id, out_data}, {1'b1, cap_i, cap_d});
      check($sformatf("bp_notake%0d", c), beat_take, 0);
    end
    @(negedge clk);
    check("bp_valid_drop", out_valid, 0);
    check("bp_one_out", n_out, base + 1);
    wait_outs(base + 2, 100, "bp_next_done");
    check("bp_next_id", last_id, 2);

    // Requester 1 drops valid after its first beat.
    check("drop_err_pre", err, 0);
    base = n_out; bt = n_takes;
    @(posedge clk); #1 drop[1] = 1'b1; rq_q[1].push_back(32'h4433_2211);
    wait_outs(base + 1, 100, "drop_done");
    check("drop_err", err, 1);
    check("drop_takes", n_takes - bt, 4);
    check("drop_id", last_id, 1);
    check("drop_data", last_data, 32'h4433_2211);

    // Reset during beat 2 of requester 2's word; afterwards requester 0 wins first.
    base = n_out; got_ids.delete(); cm_delay = 1;
    @(posedge clk); #1 rq_q[0].push_back(32'h0102_0304); rq_q[2].push_back(32'hA0B0_C0D0);
    k = 0; seen = 0;
    while (seen < 2 && k < 100) begin
      @(negedge clk); k++;
      if (beat_take != '0) seen++;
    end
    check("rst_reach_beat2", seen, 2);
    check("rst_grant_pre", beat_take, 4'b0100);
    #1 rst_n = 1'b0;
    #1 check("rst_async", {beat_take, commut_start, commut_in, out_valid, out_data, out_id, busy, err}, 64'd0);
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    wait_outs(base + 2, 200, "rst_done");
    gv = (got_ids.size() > 0) ? int'(got_ids[0]) : 99;
    check("rst_first_id", gv, 0);
    gv = (got_ids.size() > 1) ? int'(got_ids[1]) : 99;
    check("rst_second_id", gv, 2);
    check("rst_err_clear", err, 0);

    // Commutator never ready: abort after TIMEOUT cycles in WAIT.
    base = n_out; saw_out = 1'b0; cm_enable = 1'b0;
    @(posedge clk); #1 rq_q[3].push_back(32'h3333_3333);
    k = 0;
    while (!err && k < 300) begin @(negedge clk); k++; end
    e_cyc = cyc;
    check("tmo_err", err, 1);
    check("tmo_lat", e_cyc - last_take_cyc, TMO + 1);
    check("tmo_no_out", saw_out, 0);
    check("tmo_sb_pending", sb.size(), 1);
    sb.delete();
    cm_enable = 1'b1; base = n_out; got_ids.delete();
    @(posedge clk); #1 rq_q[3].push_back(32'h3C3C_3C3C); rq_q[0].push_back(32'h0F0F_0F0F);
    wait_outs(base + 2, 200, "tmo_after_done");
    gv = (got_ids.size() > 0) ? int'(got_ids[0]) : 99;
    check("tmo_next_id0", gv, 0);
    gv = (got_ids.size() > 1) ? int'(got_ids[1]) : 99;
    check("tmo_next_id1", gv, 3);
    check("tmo_err_sticky", err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
